// File: rtl/m2_pkg.sv
// Shared types and constants for the M2 block fetch: FSM states, segment codes, block limits, row widths.
// Combinational helpers only; no timing or flow control lives here.
package m2_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } m2_fetch_state_t;

  localparam logic [1:0] SEG_Y   = 2'd0;
  localparam logic [1:0] SEG_U   = 2'd1;
  localparam logic [1:0] SEG_V   = 2'd2;
  localparam logic [1:0] SEG_INV = 2'd3;

  localparam logic [5:0] Y_BLK_COLS = 6'd40;
  localparam logic [5:0] C_BLK_COLS = 6'd20;
  localparam logic [4:0] BLK_ROWS   = 5'd30;

  localparam int Y_ROW_W = 320;
  localparam int C_ROW_W = 160;

  // Chroma planes are half width, so they share the smaller column limit.
  function automatic logic req_legal(input logic [1:0] seg,
                                     input logic [5:0] blk_col,
                                     input logic [4:0] blk_row);
    logic [5:0] col_lim;
    col_lim = (seg == SEG_Y) ? Y_BLK_COLS : C_BLK_COLS;
    return (seg != SEG_INV) && (blk_col < col_lim) && (blk_row < BLK_ROWS);
  endfunction

endpackage

// File: rtl/m2_fetch_addr_gen.sv
// Maps latched block coordinates plus sample index (r = idx/8, c = idx%8) to an 18-bit SRAM word address.
// Purely combinational, zero latency; no flow control.
module m2_fetch_addr_gen
  import m2_pkg::*;
#(
  parameter logic [17:0] Y_BASE = 18'd76800,
  parameter logic [17:0] U_BASE = 18'd153600,
  parameter logic [17:0] V_BASE = 18'd192000
) (
  input  logic [1:0]  seg,
  input  logic [5:0]  blk_col,
  input  logic [4:0]  blk_row,
  input  logic [5:0]  idx,
  output logic [17:0] addr
);

  logic [17:0] row_pix;
  logic [17:0] col_pix;
  logic [17:0] row_off;
  logic [17:0] base;

  // 8*blk_row + r and 8*blk_col + c are plain bit concatenations.
  assign row_pix = {10'd0, blk_row, idx[5:3]};
  assign col_pix = {9'd0, blk_col, idx[2:0]};

  // Row stride by shift-add: 320 = 256 + 64, 160 = 128 + 32.
  always_comb begin
    base    = V_BASE;
    row_off = (row_pix << 7) + (row_pix << 5);
    case (seg)
      SEG_Y: begin
        base    = Y_BASE;
        row_off = (row_pix << 8) + (row_pix << 6);
      end
      SEG_U: base = U_BASE;
      default: base = V_BASE;
    endcase
  end

  assign addr = base + row_off + col_pix;

endmodule

// File: rtl/m2_fetch_ctrl.sv
// Fetches one 8x8 block of 16-bit samples from SRAM and packs sample pairs into 32 DP-RAM words; 67 busy cycles per block.
// No backpressure: start is taken only when idle. Define M2_FETCH_PERF_CNT_EN to build the busy-cycle counter.
module m2_fetch_ctrl
  import m2_pkg::*;
#(
  parameter logic [17:0] Y_BASE = 18'd76800,
  parameter logic [17:0] U_BASE = 18'd153600,
  parameter logic [17:0] V_BASE = 18'd192000
) (
  input  logic        CLOCK_50_I,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  seg,
  input  logic [5:0]  blk_col,
  input  logic [4:0]  blk_row,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic [6:0]  dp_address,
  output logic [31:0] dp_write_data,
  output logic        dp_wren,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] cycle_count
);

  m2_fetch_state_t state;
  logic [1:0]  seg_q;
  logic [5:0]  col_q;
  logic [4:0]  row_q;
  logic [5:0]  k_q;
  logic        drain_q;
  logic        idle;
  logic        accept;
  logic        reject;

  logic [1:0]  ag_seg;
  logic [5:0]  ag_col;
  logic [4:0]  ag_row;
  logic [5:0]  ag_idx;
  logic [17:0] ag_addr;

  // Read pipeline: stage 2 lines up with the sample arriving on SRAM_read_data.
  logic        p1_vld;
  logic        p2_vld;
  logic [5:0]  p1_idx;
  logic [5:0]  p2_idx;
  logic [15:0] even_q;

  assign idle   = (state == S_IDLE);
  assign accept = idle && start && req_legal(seg, blk_col, blk_row);
  assign reject = idle && start && !req_legal(seg, blk_col, blk_row);

  // While idle the generator sees the live request so sample 0 is issued on the accept edge.
  assign ag_seg = idle ? seg     : seg_q;
  assign ag_col = idle ? blk_col : col_q;
  assign ag_row = idle ? blk_row : row_q;
  assign ag_idx = idle ? 6'd0    : k_q + 6'd1;

  m2_fetch_addr_gen #(
    .Y_BASE (Y_BASE),
    .U_BASE (U_BASE),
    .V_BASE (V_BASE)
  ) u_addr_gen (
    .seg     (ag_seg),
    .blk_col (ag_col),
    .blk_row (ag_row),
    .idx     (ag_idx),
    .addr    (ag_addr)
  );

  always_ff @(posedge CLOCK_50_I or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      seg_q        <= 2'd0;
      col_q        <= 6'd0;
      row_q        <= 5'd0;
      k_q          <= 6'd0;
      drain_q      <= 1'b0;
      SRAM_address <= 18'd0;
      err          <= 1'b0;
    end else begin
      err <= reject;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state        <= S_FETCH;
            seg_q        <= seg;
            col_q        <= blk_col;
            row_q        <= blk_row;
            k_q          <= 6'd0;
            SRAM_address <= ag_addr;
          end
        end
        S_FETCH: begin
          if (k_q == 6'd63) begin
            state   <= S_DRAIN;
            drain_q <= 1'b0;
          end else begin
            k_q          <= k_q + 6'd1;
            SRAM_address <= ag_addr;
          end
        end
        S_DRAIN: begin
          if (drain_q) state <= S_DONE;
          else         drain_q <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50_I or posedge reset) begin
    if (reset) begin
      p1_vld <= 1'b0;
      p2_vld <= 1'b0;
      p1_idx <= 6'd0;
      p2_idx <= 6'd0;
      even_q <= 16'd0;
    end else begin
      p1_vld <= (state == S_FETCH);
      p1_idx <= k_q;
      p2_vld <= p1_vld;
      p2_idx <= p1_idx;
      if (p2_vld && !p2_idx[0]) even_q <= SRAM_read_data;
    end
  end

  // Odd samples complete a pair; address is 4*r + c/2.
  assign dp_wren       = p2_vld && p2_idx[0];
  assign dp_address    = {2'b00, p2_idx[5:3], p2_idx[2:1]};
  assign dp_write_data = dp_wren ? {even_q, SRAM_read_data} : 32'd0;
  assign SRAM_we_n     = 1'b1;
  assign busy          = !idle;
  assign done          = (state == S_DONE);

`ifdef M2_FETCH_PERF_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge CLOCK_50_I or posedge reset) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else if (accept) begin
      cnt_q <= 16'd0;
    end else if (busy && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = 16'd0;
`endif

endmodule
